// File: rtl/wash_plant_model.sv
// rtl/wash_plant_model.sv - plant model of the wash drum: tank level, phase tracking, protocol faults
// Optional first-fault capture: define WASH_PLANT_STICKY_FAULT_EN.
module wash_plant_model #(
  parameter int MOTOR_W    = 2,
  parameter int LVL_W      = 6,
  parameter int LVL_MAX    = 40,
  parameter int FILL_RATE  = 2,
  parameter int DRAIN_RATE = 3,
  parameter int RUN_CNT_W  = 6,
  parameter int GAP_CYC    = 8,
  parameter int GAP_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MOTOR_W-1:0]   motor,
  input  logic                 water_in,
  input  logic                 water_out,
  output logic [LVL_W-1:0]     level,
  output logic                 full,
  output logic                 empty,
  output logic [2:0]           phase,
  output logic [RUN_CNT_W-1:0] run_cnt,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic                 cycle_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, FILL = 3'd1, AGITATE = 3'd2, DRAIN = 3'd3, SPIN = 3'd4, DONE = 3'd5
  } phase_t;

`ifdef WASH_PLANT_STICKY_FAULT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [MOTOR_W-1:0] M_STOP  = '0;
  localparam logic [MOTOR_W-1:0] M_CW    = MOTOR_W'(1);
  localparam logic [MOTOR_W-1:0] M_ILL   = '1;
  localparam logic [LVL_W:0]     MAX_X   = (LVL_W+1)'(LVL_MAX);
  localparam logic [LVL_W:0]     FILL_X  = (LVL_W+1)'(FILL_RATE);
  localparam logic [LVL_W:0]     DRAIN_X = (LVL_W+1)'(DRAIN_RATE);
  localparam logic [GAP_W-1:0]   GAP_X   = GAP_W'(GAP_CYC);

  phase_t                 phase_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   full_q, empty_q;
  logic [RUN_CNT_W-1:0]   run_cnt_q;
  logic                   fault_q;
  logic [1:0]             fault_code_q, code_d;
  logic                   cycle_done_q;
  logic [MOTOR_W-1:0]     last_dir_q, dir_eff;
  logic [GAP_W-1:0]       quiet_q, quiet_d;
  logic [LVL_W:0]         sum_x;
  logic                   quiet_now, run_start, run_bump;

  always_comb begin
    dir_eff = (motor == M_ILL) ? M_STOP : motor;
    sum_x   = '0;
    level_d = level_q;
    if (water_in && !water_out) begin
      sum_x   = {1'b0, level_q} + FILL_X;
      level_d = (sum_x > MAX_X) ? MAX_X[LVL_W-1:0] : sum_x[LVL_W-1:0];
    end else if (water_out && !water_in) begin
      // Extra top bit acts as the borrow flag on underflow.
      sum_x   = {1'b0, level_q} - DRAIN_X;
      level_d = sum_x[LVL_W] ? '0 : sum_x[LVL_W-1:0];
    end
    quiet_now = (dir_eff == M_STOP) && !water_in && !water_out;
    quiet_d   = !quiet_now ? '0 : ((quiet_q == GAP_X) ? GAP_X : quiet_q + GAP_W'(1));
    run_start = (last_dir_q == M_STOP) && (dir_eff != M_STOP);
    run_bump  = run_start && (run_cnt_q != '1);
    code_d    = 2'd0;
    if (water_in && water_out)
      code_d = 2'd1;
    else if (motor == M_ILL)
      code_d = 2'd2;
    else if ((last_dir_q != M_STOP) && (dir_eff != M_STOP) && (dir_eff != last_dir_q))
      code_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= IDLE;
      level_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      run_cnt_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
      cycle_done_q <= 1'b0;
      last_dir_q   <= M_STOP;
      quiet_q      <= '0;
    end else begin
      level_q      <= level_d;
      full_q       <= (level_d == MAX_X[LVL_W-1:0]);
      empty_q      <= (level_d == '0);
      quiet_q      <= quiet_d;
      last_dir_q   <= dir_eff;
      cycle_done_q <= 1'b0;
      if ((code_d != 2'd0) && !(STICKY && fault_q)) begin
        fault_q      <= 1'b1;
        fault_code_q <= code_d;
      end
      // Quiet-gap abort overrides every other move out of an active phase.
      if ((phase_q == FILL || phase_q == AGITATE || phase_q == DRAIN) && quiet_d == GAP_X) begin
        phase_q <= IDLE;
        if (!STICKY) begin
          fault_q      <= 1'b0;
          fault_code_q <= 2'd0;
        end
      end else begin
        case (phase_q)
          IDLE: if (water_in) begin
            phase_q   <= FILL;
            run_cnt_q <= '0;
          end
          FILL: if (water_out) phase_q <= DRAIN;
                else if (!water_in && dir_eff != M_STOP) begin
                  phase_q <= AGITATE;
                  if (run_bump) run_cnt_q <= run_cnt_q + RUN_CNT_W'(1);
                end
          AGITATE: if (water_out) phase_q <= DRAIN;
                   else if (water_in) phase_q <= FILL;
                   else if (run_bump) run_cnt_q <= run_cnt_q + RUN_CNT_W'(1);
          DRAIN: if (water_in) phase_q <= FILL;
                 else if (empty_q && motor == M_CW) phase_q <= SPIN;
          SPIN: if (quiet_d == GAP_X) begin
            phase_q      <= DONE;
            cycle_done_q <= 1'b1;
          end
          DONE: begin
            phase_q <= IDLE;
            if (!STICKY) begin
              fault_q      <= 1'b0;
              fault_code_q <= 2'd0;
            end
          end
          default: phase_q <= IDLE;
        endcase
      end
    end
  end

  assign level      = level_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign phase      = phase_q;
  assign run_cnt    = run_cnt_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign cycle_done = cycle_done_q;

endmodule
